// File: rtl/edge_event_arbiter.sv
// rtl/edge_event_arbiter.sv - per-channel edge capture serialised onto one valid/ready event port
// Round-robin arbitration over pending edges, one event per cycle when the consumer keeps up.
module edge_event_arbiter #(
   parameter int NCH  = 4,
   parameter int CH_W = 2
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [NCH-1:0]  level,
   input  logic [NCH-1:0]  ch_en,
   input  logic            evt_ready,
   output logic            evt_valid,
   output logic [CH_W-1:0] evt_ch,
   output logic            evt_rise,
   input  logic            ovf_clr,
   output logic [NCH-1:0]  overflow
);

   typedef enum logic {IDLE, PRESENT} state_t;

   state_t          state;
   logic [NCH-1:0]  prev;
   logic [NCH-1:0]  pend;
   logic [NCH-1:0]  pend_rise;
   logic [NCH-1:0]  rise;
   logic [NCH-1:0]  fall;
   logic [NCH-1:0]  req;
   logic [NCH-1:0]  grant_oh;
   logic [NCH-1:0]  set_ovf;
   logic [CH_W-1:0] last_grant;
   logic [CH_W-1:0] grant_idx;
   logic            any_req;
   logic            load;
   logic            found;
   int              idx;

   assign rise    = level & ~prev;
   assign fall    = ~level & prev;
   // Disabled channels never win, so a flush cannot race a grant.
   assign req     = pend & ch_en;
   assign any_req = |req;
   assign load    = any_req && ((state == IDLE) || evt_ready);

   always_comb begin
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int off = 1; off <= NCH; off++) begin
         idx = int'(last_grant) + off;
         if (idx >= NCH) idx = idx - NCH;
         if (!found && req[idx]) begin
            found     = 1'b1;
            grant_idx = CH_W'(idx);
         end
      end
   end

   assign grant_oh = load ? (NCH'(1) << grant_idx) : '0;
   // A held pending slot keeps the oldest edge; a newer one is only recorded as lost.
   assign set_ovf  = ch_en & (rise | fall) & pend & ~grant_oh;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         prev       <= '0;
         pend       <= '0;
         pend_rise  <= '0;
         overflow   <= '0;
         evt_valid  <= 1'b0;
         evt_ch     <= '0;
         evt_rise   <= 1'b0;
         last_grant <= CH_W'(NCH - 1);
      end else begin
         prev     <= level;
         overflow <= (ovf_clr ? '0 : overflow) | set_ovf;

         for (int i = 0; i < NCH; i++) begin
            if (!ch_en[i]) begin
               pend[i] <= 1'b0;
            end else if (rise[i] || fall[i]) begin
               if (!pend[i] || grant_oh[i]) begin
                  pend[i]      <= 1'b1;
                  pend_rise[i] <= rise[i];
               end
            end else if (grant_oh[i]) begin
               pend[i] <= 1'b0;
            end
         end

         case (state)
            IDLE: begin
               if (load) begin
                  state      <= PRESENT;
                  evt_valid  <= 1'b1;
                  evt_ch     <= grant_idx;
                  evt_rise   <= pend_rise[grant_idx];
                  last_grant <= grant_idx;
               end
            end
            PRESENT: begin
               if (evt_ready) begin
                  if (load) begin
                     evt_ch     <= grant_idx;
                     evt_rise   <= pend_rise[grant_idx];
                     last_grant <= grant_idx;
                  end else begin
                     state     <= IDLE;
                     evt_valid <= 1'b0;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               evt_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
